// File: rtl/nic_reset_intr_ctrl_pkg.sv
// Shared definitions for the NIC reset sequencer / interrupt aggregator slice:
// reset FSM encodings, default timing constants and a counter-width helper.
package nic_reset_intr_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_HOLD  = 2'd1,
    S_RUN   = 2'd2
  } rst_state_e;

  localparam int DEF_HOLD_CYCLES = 64;
  localparam int DEF_GAP_CYCLES  = 0;

  // Bits needed to hold 0..max_val, never less than one so a disabled counter still exists.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/nic_reset_intr_ctrl_sync_bit.sv
// Single-bit multi-flop synchronizer for one asynchronous interrupt input.
// Clears on the block reset only, so it keeps tracking inputs while the NIC domain is held in reset.
module nic_reset_intr_ctrl_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic RST,
  input  logic async_in,
  output logic sync_out
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge aclk) begin
    if (RST) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/nic_reset_intr_ctrl.sv
// NIC top-level reset sequencer (lock + request driven, programmable hold) and
// interrupt aggregator (sync, edge/level, mask, ack, minimum-gap throttle) onto PCI INT_N.
module nic_reset_intr_ctrl
  import nic_reset_intr_ctrl_pkg::*;
#(
  parameter int                  NUM_RST_SRC     = 1,
  parameter int                  RST_HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int                  NUM_INTR        = 1,
  parameter int                  SYNC_STAGES     = 2,
  parameter logic [NUM_INTR-1:0] INTR_EDGE       = '0,
  parameter int                  ITR_GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   clk_locked,
  input  logic [NUM_RST_SRC-1:0] rst_request,
  output logic                   aresetn,
  output logic                   rst_active,
  input  logic [NUM_INTR-1:0]    intr_in,
  input  logic [NUM_INTR-1:0]    intr_mask,
  input  logic [NUM_INTR-1:0]    intr_ack,
  output logic [NUM_INTR-1:0]    intr_pending,
  output logic                   INT_N
);

  localparam int HW = cnt_width(RST_HOLD_CYCLES);
  localparam int GW = cnt_width(ITR_GAP_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(ITR_GAP_CYCLES);

  rst_state_e state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic          release_ok;

  logic [NUM_INTR-1:0] sync_q, sync_d;
  logic                raw;
  logic                int_n_next;
  logic [GW-1:0]       gap_cnt, gap_next;

  assign release_ok = clk_locked && !(|rst_request);
  assign aresetn    = (state == S_RUN);
  assign rst_active = !aresetn;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_RESET;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

  // Any loss of lock or request during hold restarts the full hold from zero.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      S_RESET: begin
        hold_next = '0;
        if (release_ok) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (!release_ok) begin
          state_next = S_RESET;
          hold_next  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = S_RUN;
          hold_next  = '0;
        end else begin
          hold_next = hold_cnt + HW'(1);
        end
      end
      S_RUN: begin
        if (!release_ok) state_next = S_RESET;
      end
      default: begin
        state_next = S_RESET;
        hold_next  = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_INTR; i++) begin : g_sync
    nic_reset_intr_ctrl_sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .aclk     (CLK),
      .RST      (RST),
      .async_in (intr_in[i]),
      .sync_out (sync_q[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_d <= '0;
    end else begin
      sync_d <= sync_q;
    end
  end

  // Edge sources latch until acked (a new edge beats a same-cycle ack); level sources follow the input.
  always_ff @(posedge CLK) begin
    if (RST || !aresetn) begin
      intr_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_INTR; i++) begin
        if (INTR_EDGE[i]) begin
          if (sync_q[i] && !sync_d[i]) begin
            intr_pending[i] <= 1'b1;
          end else if (intr_ack[i]) begin
            intr_pending[i] <= 1'b0;
          end
        end else begin
          intr_pending[i] <= sync_q[i];
        end
      end
    end
  end

  assign raw = |(intr_pending & intr_mask);

  // Throttle window opens on each INT_N release and blocks re-assertion until it drains.
  always_comb begin
    int_n_next = INT_N;
    gap_next   = gap_cnt;
    if (!raw) begin
      int_n_next = 1'b1;
    end else if (gap_cnt == '0) begin
      int_n_next = 1'b0;
    end
    if (!INT_N && int_n_next) begin
      gap_next = GAP_LOAD;
    end else if (gap_cnt != '0) begin
      gap_next = gap_cnt - GW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || !aresetn) begin
      INT_N   <= 1'b1;
      gap_cnt <= '0;
    end else begin
      INT_N   <= int_n_next;
      gap_cnt <= gap_next;
    end
  end

endmodule

// File: tb/tb_nic_reset_intr_ctrl.sv
// Directed bench for nic_reset_intr_ctrl: reset sequencing, hold aborts, edge/level
// interrupts, mask/ack handling, INT_N throttle and reset while an interrupt is active.
module tb_nic_reset_intr_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       clk_locked;
  logic [1:0] rst_request;
  logic       aresetn;
  logic       rst_active;
  logic [1:0] intr_in;
  logic [1:0] intr_mask;
  logic [1:0] intr_ack;
  logic [1:0] intr_pending;
  logic       INT_N;

  int total_count = 0;
  int bad_count   = 0;
  int high_count;

  always #5 CLK = ~CLK;

  nic_reset_intr_ctrl #(
    .NUM_RST_SRC     (2),
    .RST_HOLD_CYCLES (8),
    .NUM_INTR        (2),
    .SYNC_STAGES     (2),
    .INTR_EDGE       (2'b01),
    .ITR_GAP_CYCLES  (10)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .clk_locked   (clk_locked),
    .rst_request  (rst_request),
    .aresetn      (aresetn),
    .rst_active   (rst_active),
    .intr_in      (intr_in),
    .intr_mask    (intr_mask),
    .intr_ack     (intr_ack),
    .intr_pending (intr_pending),
    .INT_N        (INT_N)
  );

  // Advance the given number of rising edges; outputs are then read 1 ns after the last edge.
  task automatic applyStimulus(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    if (observed !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST         = 1'b1;
    clk_locked  = 1'b1;
    rst_request = 2'b00;
    intr_in     = 2'b00;
    intr_mask   = 2'b00;
    intr_ack    = 2'b00;
    applyStimulus(4);
    checkOutput("rst_aresetn",    aresetn,      0);
    checkOutput("rst_rst_active", rst_active,   1);
    checkOutput("rst_int_n",      INT_N,        1);
    checkOutput("rst_pending",    intr_pending, 0);

    // power-up hold: release after 9 edges
    RST = 1'b0;
    applyStimulus(8);
    checkOutput("hold_8_aresetn", aresetn, 0);
    applyStimulus(1);
    checkOutput("hold_9_aresetn", aresetn, 1);
    checkOutput("hold_9_active",  rst_active, 0);

    // single-cycle reset request
    rst_request = 2'b01;
    applyStimulus(1);
    rst_request = 2'b00;
    checkOutput("req_aresetn_fall", aresetn, 0);
    checkOutput("req_active",       rst_active, 1);
    applyStimulus(8);
    checkOutput("req_8_aresetn", aresetn, 0);
    applyStimulus(1);
    checkOutput("req_9_aresetn", aresetn, 1);

    // lock lost at hold count 5 restarts the sequence
    rst_request = 2'b10;
    applyStimulus(1);
    rst_request = 2'b00;
    applyStimulus(6);
    clk_locked = 1'b0;
    applyStimulus(1);
    clk_locked = 1'b1;
    checkOutput("abort_aresetn", aresetn, 0);
    applyStimulus(8);
    checkOutput("abort_8_aresetn", aresetn, 0);
    applyStimulus(1);
    checkOutput("abort_9_aresetn", aresetn, 1);

    // edge source latency
    intr_mask = 2'b11;
    intr_in   = 2'b01;
    applyStimulus(2);
    checkOutput("edge_pend_early", intr_pending, 2'b00);
    applyStimulus(1);
    checkOutput("edge_pend_set",  intr_pending, 2'b01);
    checkOutput("edge_int_n_hi",  INT_N, 1);
    applyStimulus(1);
    checkOutput("edge_int_n_lo",  INT_N, 0);

    // ack clears, INT_N releases one edge later
    intr_ack = 2'b01;
    applyStimulus(1);
    intr_ack = 2'b00;
    checkOutput("ack_pend_clr",  intr_pending, 2'b00);
    checkOutput("ack_int_n_lag", INT_N, 0);
    applyStimulus(1);
    checkOutput("ack_int_n_hi",  INT_N, 1);

    // ack coincident with a new edge: set wins
    intr_in = 2'b00;
    applyStimulus(3);
    intr_in = 2'b01;
    applyStimulus(2);
    intr_ack = 2'b01;
    applyStimulus(1);
    intr_ack = 2'b00;
    checkOutput("ack_vs_edge_pend", intr_pending, 2'b01);
    applyStimulus(4);
    checkOutput("gap_still_hi", INT_N, 1);
    applyStimulus(1);
    checkOutput("gap_done_lo",  INT_N, 0);

    // throttle: ack, new edge two cycles later, INT_N held off by the gap
    intr_in = 2'b00;
    applyStimulus(3);
    checkOutput("edge_latched", intr_pending, 2'b01);
    intr_ack = 2'b01;
    applyStimulus(1);
    intr_ack = 2'b00;
    intr_in  = 2'b01;
    checkOutput("thr_pend_clr", intr_pending, 2'b00);
    applyStimulus(1);
    checkOutput("thr_deassert", INT_N, 1);
    high_count = 0;
    for (int n = 0; n < 10; n++) begin
      applyStimulus(1);
      if (INT_N) high_count++;
    end
    checkOutput("thr_high_cycles", high_count, 10);
    checkOutput("thr_pend_reset",  intr_pending, 2'b01);
    applyStimulus(1);
    checkOutput("thr_reassert", INT_N, 0);

    // masked level source
    intr_ack = 2'b01;
    applyStimulus(1);
    intr_ack  = 2'b00;
    intr_mask = 2'b01;
    intr_in   = 2'b11;
    applyStimulus(1);
    checkOutput("lvl_int_n_rel", INT_N, 1);
    applyStimulus(2);
    checkOutput("lvl_pend",      intr_pending, 2'b10);
    checkOutput("lvl_masked",    INT_N, 1);
    applyStimulus(8);
    checkOutput("lvl_masked_late", INT_N, 1);
    intr_mask = 2'b11;
    applyStimulus(1);
    checkOutput("lvl_unmask", INT_N, 0);
    intr_ack = 2'b10;
    applyStimulus(1);
    intr_ack = 2'b00;
    checkOutput("lvl_ack_ignored", intr_pending, 2'b10);
    intr_mask = 2'b01;
    applyStimulus(1);
    checkOutput("lvl_remask_int_n", INT_N, 1);
    checkOutput("lvl_remask_pend",  intr_pending, 2'b10);
    intr_mask = 2'b11;
    applyStimulus(11);
    checkOutput("lvl_reenable", INT_N, 0);

    // reset request while INT_N is asserted
    rst_request = 2'b10;
    applyStimulus(1);
    rst_request = 2'b00;
    checkOutput("mid_aresetn",   aresetn, 0);
    checkOutput("mid_int_n_lag", INT_N, 0);
    applyStimulus(1);
    checkOutput("mid_int_n_hi",  INT_N, 1);
    checkOutput("mid_pend_clr",  intr_pending, 2'b00);
    high_count = 0;
    for (int n = 0; n < 8; n++) begin
      applyStimulus(1);
      if (INT_N) high_count++;
    end
    checkOutput("mid_quiet_cycles", high_count, 8);
    checkOutput("mid_run_again",    aresetn, 1);
    applyStimulus(1);
    checkOutput("mid_pend_back",    intr_pending, 2'b10);
    applyStimulus(1);
    checkOutput("mid_int_n_back",   INT_N, 0);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
